seq_multiplier: RTL and testbench

//   Parametrised iterative shift-add multiplier; next generation of the 4-bit int multiplier.

---
 rtl/seq_multiplier.sv | 105 ++++++++++
 tb/tb_seq_multiplier.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier, one partial-product step per clock.
// Signed mode multiplies magnitudes and applies the result sign at completion.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               sign;
  logic               last;

  assign busy = (state == RUN);
  assign last = (count == CW'(WIDTH - 1));

  // Operand magnitudes; -2^(W-1) still fits as a W-bit unsigned value
  always_comb begin
    mag_a = a;
    mag_b = b;
    if (is_signed && a[WIDTH-1]) mag_a = '0 - a;
    if (is_signed && b[WIDTH-1]) mag_b = '0 - b;
  end

  // Accumulator after the current step, so completion can use it directly
  always_comb begin
    acc_step = acc;
    if (mplier[0]) acc_step = acc + mcand;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add steps, result and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      sign    <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc    <= '0;
            count  <= '0;
          end
        end
        RUN: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last) begin
            product <= sign ? ('0 - acc_step) : acc_step;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=4 and WIDTH=8 instances).
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, is_signed4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  product4;
  logic        start8, is_signed8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] product8;

  int chk  = 0;
  int errs = 0;

  logic [7:0]  sb4[$];
  logic [15:0] sb8[$];

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .is_signed(is_signed4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(product4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(is_signed8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(product8)
  );

  // Independent reference: sign-extend by hand and multiply as integers
  function automatic logic [7:0] ref4(input logic s, input logic [3:0] x, input logic [3:0] y);
    int xi, yi;
    xi = int'(x);
    yi = int'(y);
    if (s && x[3]) xi = xi - 16;
    if (s && y[3]) yi = yi - 16;
    return 8'(xi * yi);
  endfunction

  // One WIDTH=4 operation, called at a negedge; chain=1 returns at the done cycle
  task automatic run_op4(input logic s, input logic [3:0] x, input logic [3:0] y,
                         input logic [7:0] exp, input string name, input logic chain);
    int edges;
    logic [7:0] want;
    sb4.push_back(exp);
    is_signed4 = s; a4 = x; b4 = y; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    edges = 1;
    chk++;
    if (busy4 !== 1'b1) begin
      errs++; $display("FAIL %s busy_after_start got %b want 1", name, busy4);
    end
    while (done4 !== 1'b1 && edges < 16) begin
      @(negedge clk);
      edges++;
    end
    chk++;
    if (done4 !== 1'b1) begin
      errs++; $display("FAIL %s timeout waiting for done", name);
      return;
    end
    want = sb4.pop_front();
    chk++;
    if (product4 !== want) begin
      errs++; $display("FAIL %s product got %h want %h", name, product4, want);
    end
    chk++;
    if (edges - 1 != 4) begin
      errs++; $display("FAIL %s latency got %0d want 4", name, edges - 1);
    end
    chk++;
    if (busy4 !== 1'b0) begin
      errs++; $display("FAIL %s busy_at_done got %b want 0", name, busy4);
    end
    if (!chain) begin
      @(negedge clk);
      chk++;
      if (done4 !== 1'b0 || product4 !== want) begin
        errs++; $display("FAIL %s done_pulse/hold got done=%b prod=%h want done=0 prod=%h",
                         name, done4, product4, want);
      end
    end
  endtask

  task automatic run_op8(input logic s, input logic [7:0] x, input logic [7:0] y,
                         input logic [15:0] exp, input string name);
    int edges;
    logic [15:0] want;
    sb8.push_back(exp);
    is_signed8 = s; a8 = x; b8 = y; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    edges = 1;
    while (done8 !== 1'b1 && edges < 32) begin
      @(negedge clk);
      edges++;
    end
    chk++;
    if (done8 !== 1'b1) begin
      errs++; $display("FAIL %s timeout waiting for done", name);
      return;
    end
    want = sb8.pop_front();
    chk++;
    if (product8 !== want) begin
      errs++; $display("FAIL %s product got %h want %h", name, product8, want);
    end
    chk++;
    if (edges - 1 != 8) begin
      errs++; $display("FAIL %s latency got %0d want 8", name, edges - 1);
    end
    @(negedge clk);
    chk++;
    if (done8 !== 1'b0 || product8 !== want) begin
      errs++; $display("FAIL %s done_pulse/hold got done=%b prod=%h", name, done8, product8);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start4 = 1'b0; is_signed4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; is_signed8 = 1'b0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'h00) begin
      errs++; $display("FAIL reset4 got busy=%b done=%b prod=%h want 0 0 00", busy4, done4, product4);
    end
    chk++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'h0000) begin
      errs++; $display("FAIL reset8 got busy=%b done=%b prod=%h want 0 0 0000", busy8, done8, product8);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    run_op4(1'b0, 4'd5,  4'd3,  8'd15,  "u_5x3",   1'b0);
    run_op4(1'b0, 4'd0,  4'd3,  8'd0,   "u_0x3",   1'b0);
    run_op4(1'b0, 4'd5,  4'd0,  8'd0,   "u_5x0",   1'b0);
    run_op4(1'b0, 4'd15, 4'd15, 8'd225, "u_15x15", 1'b0);
  endtask

  task automatic test_signed();
    run_op4(1'b1, 4'hD, 4'h5, 8'hF1, "s_m3x5",  1'b0);
    run_op4(1'b1, 4'h8, 4'h8, 8'h40, "s_m8xm8", 1'b0);
    run_op4(1'b1, 4'h7, 4'h8, 8'hC8, "s_7xm8",  1'b0);
  endtask

  task automatic test_mode();
    run_op4(1'b0, 4'hD, 4'h5, 8'd65, "u_13x5", 1'b0);
    for (int unsigned i = 0; i < 8; i++) begin
      logic s;
      logic [3:0] x, y;
      s = 1'($urandom_range(0, 1));
      x = 4'($urandom);
      y = 4'($urandom);
      run_op4(s, x, y, ref4(s, x, y), "rand", 1'b0);
    end
  endtask

  task automatic test_ignore_start();
    logic [7:0] want;
    int edges;
    sb4.push_back(8'd15);
    is_signed4 = 1'b0; a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    start4 = 1'b1; is_signed4 = 1'b1; a4 = 4'hF; b4 = 4'hF;
    @(negedge clk);
    chk++;
    if (busy4 !== 1'b1) begin
      errs++; $display("FAIL ignore busy got %b want 1", busy4);
    end
    a4 = 4'h9; b4 = 4'h7;
    @(negedge clk);
    start4 = 1'b0;
    edges = 0;
    while (done4 !== 1'b1 && edges < 16) begin
      @(negedge clk);
      edges++;
    end
    chk++;
    if (done4 !== 1'b1) begin
      errs++; $display("FAIL ignore timeout waiting for done");
      return;
    end
    want = sb4.pop_front();
    chk++;
    if (product4 !== want) begin
      errs++; $display("FAIL ignore product got %h want %h", product4, want);
    end
    @(negedge clk);
    chk++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errs++; $display("FAIL ignore queued got busy=%b done=%b want 0 0", busy4, done4);
    end
  endtask

  task automatic test_reset_midrun();
    is_signed4 = 1'b0; a4 = 4'd5; b4 = 4'd3; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'h00) begin
      errs++; $display("FAIL reset_mid got busy=%b done=%b prod=%h want 0 0 00", busy4, done4, product4);
    end
    run_op4(1'b0, 4'd2, 4'd3, 8'd6, "after_reset", 1'b0);
    reset = 1'b1; start4 = 1'b1; a4 = 4'd7; b4 = 4'd7;
    @(negedge clk);
    reset = 1'b0; start4 = 1'b0;
    @(negedge clk);
    chk++;
    if (busy4 !== 1'b0 || product4 !== 8'h00) begin
      errs++; $display("FAIL reset_with_start got busy=%b prod=%h want 0 00", busy4, product4);
    end
  endtask

  task automatic test_back_to_back();
    run_op4(1'b0, 4'd9, 4'd9, 8'd81,  "b2b_1", 1'b1);
    run_op4(1'b1, 4'hE, 4'h3, 8'hFA,  "b2b_2", 1'b1);
    run_op4(1'b0, 4'd12, 4'd11, 8'd132, "b2b_3", 1'b0);
  endtask

  task automatic test_width8();
    run_op8(1'b0, 8'd255, 8'd255, 16'hFE01, "w8_255x255");
    run_op8(1'b1, 8'h80,  8'h7F,  16'hC080, "w8_s_m128x127");
    run_op8(1'b1, 8'h80,  8'h80,  16'h4000, "w8_s_m128xm128");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mode();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_width8();
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
